// File: rtl/class_arbiter_pkg.sv
// Shared definitions for the class arbiter: link-state encodings, word layout
// and the two-phase grant FSM states.
package class_arbiter_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int CLASS_MSB  = 11;
    localparam int CLASS_LSB  = 10;
    localparam int DEST_BIT   = 9;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    typedef enum logic {
        PH_GRANT   = 1'b0,
        PH_RECOVER = 1'b1
    } phase_e;

endpackage

// File: rtl/class_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: the first requester at or after ptr
// (wrapping 3 -> 0) wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] cand;

    // Walk from the farthest offset back to ptr so the closest requester is the last writer.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        cand      = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/class_arbiter.sv
// Drains four class FIFOs round-robin, one word per two cycles, and routes each
// word to destination FIFO d0 or d1 by its DEST_BIT.
module class_arbiter
    import class_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    input  logic                  almost_full_d0,
    input  logic                  almost_full_d1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  idle
);

    logic [3:0]            empty_v;
    logic [DATA_WIDTH-1:0] word [4];
    logic [3:0]            eligible;
    logic                  gnt_valid;
    logic [1:0]            gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_word;
    logic                  run;

    phase_e                phase_q,    phase_d;
    logic [1:0]            rr_ptr_q,   rr_ptr_d;
    logic [3:0]            pop_q,      pop_d;
    logic [1:0]            push_q,     push_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  idle_q,     idle_d;

    assign empty_v = {empty_3, empty_2, empty_1, empty_0};
    assign word[0] = data_in_0;
    assign word[1] = data_in_1;
    assign word[2] = data_in_2;
    assign word[3] = data_in_3;
    assign run     = (state == ST_IDLE) || (state == ST_ACTIVE);

    // A class whose destination is nearly full is skipped, not waited on.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eligible = '0;
        for (int n = 0; n < 4; n++) begin
            eligible[n] = !empty_v[n] &&
                          !(word[n][DEST_BIT] ? almost_full_d1 : almost_full_d0);
        end
    end

    rr_pick4 u_pick (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_word = word[gnt_idx];

    always_comb begin
        phase_d    = phase_q;
        rr_ptr_d   = rr_ptr_q;
        pop_d      = '0;
        push_d     = '0;
        data_out_d = data_out_q;
        idle_d     = idle_q;
        if (state == ST_RESET) begin
            phase_d    = PH_GRANT;
            rr_ptr_d   = '0;
            data_out_d = '0;
            idle_d     = 1'b1;
        end else if (run) begin
            idle_d = (&empty_v) && (phase_q == PH_GRANT) && (push_q == 2'b00);
            if (phase_q == PH_GRANT) begin
                if (gnt_valid) begin
                    pop_d[gnt_idx]            = 1'b1;
                    push_d[gnt_word[DEST_BIT]] = 1'b1;
                    data_out_d                = gnt_word;
                    rr_ptr_d                  = gnt_idx + 2'd1;
                    phase_d                   = PH_RECOVER;
                end
            end else begin
                // FIFO flags need a cycle to reflect the pop before the next search.
                phase_d = PH_GRANT;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_GRANT;
            rr_ptr_q   <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            data_out_q <= '0;
            idle_q     <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            rr_ptr_q   <= rr_ptr_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            data_out_q <= data_out_d;
            idle_q     <= idle_d;
        end
    end

    assign pop_0    = pop_q[0];
    assign pop_1    = pop_q[1];
    assign pop_2    = pop_q[2];
    assign pop_3    = pop_q[3];
    assign push_d0  = push_q[0];
    assign push_d1  = push_q[1];
    assign data_out = data_out_q;
    assign idle     = idle_q;

endmodule
